// File: rtl/ws2812_tx.sv
// rtl/ws2812_tx.sv - WS2812 single-wire serial encoder fed by a byte stream
module ws2812_tx #(
  parameter int T0H          = 8,
  parameter int T1H          = 17,
  parameter int TBIT         = 30,
  parameter int RESET_CYCLES = 1920
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] bytecount,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        dout,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  // One phase counter serves both the bit timing and the latch gap.
  localparam int PMAX = (TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);

  localparam logic [PW-1:0] T0H_END  = PW'(T0H - 1);
  localparam logic [PW-1:0] T1H_END  = PW'(T1H - 1);
  localparam logic [PW-1:0] TBIT_END = PW'(TBIT - 1);
  localparam logic [PW-1:0] RST_END  = PW'(RESET_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_HIGH,
    S_LOW,
    S_LATCH
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [PW-1:0] phase;
  logic [7:0]    shifter;
  logic [2:0]    bit_idx;
  logic [7:0]    hold;
  logic          hold_full;
  logic [15:0]   accepted;
  logic [15:0]   sent;
  logic [15:0]   bytecount_reg;

  logic          hs;
  logic [PW-1:0] high_end;
  logic          frame_start;
  logic          take_hold;
  logic          take_in;
  logic          shift_en;
  logic          byte_end;
  logic          set_underrun;
  logic          latch_end;

  // Bytes are only taken mid-frame, with room in the holding register and
  // while the frame still owes bytes; the latch gap never takes data.
  assign busy     = (state != S_IDLE);
  assign in_ready = busy & ~hold_full & (accepted < bytecount_reg) & (state != S_LATCH);
  assign hs       = in_valid & in_ready;
  assign high_end = shifter[7] ? T1H_END : T0H_END;
  assign done     = latch_end;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_n      = state;
    frame_start  = 1'b0;
    take_hold    = 1'b0;
    take_in      = 1'b0;
    shift_en     = 1'b0;
    byte_end     = 1'b0;
    set_underrun = 1'b0;
    latch_end    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          frame_start = 1'b1;
          state_n     = (bytecount == 16'd0) ? S_LATCH : S_WAIT;
        end
      end
      S_WAIT: begin
        if (hold_full) begin
          take_hold = 1'b1;
          state_n   = S_HIGH;
        end else if (hs) begin
          take_in = 1'b1;
          state_n = S_HIGH;
        end
      end
      S_HIGH: begin
        if (phase == high_end) begin
          state_n = S_LOW;
        end
      end
      S_LOW: begin
        if (phase == TBIT_END) begin
          if (bit_idx != 3'd0) begin
            shift_en = 1'b1;
            state_n  = S_HIGH;
          end else begin
            byte_end = 1'b1;
            if (sent + 16'd1 == bytecount_reg) begin
              state_n = S_LATCH;
            end else if (hold_full) begin
              take_hold = 1'b1;
              state_n   = S_HIGH;
            end else begin
              // Line simply stays low until the next byte shows up.
              set_underrun = 1'b1;
              state_n      = S_WAIT;
            end
          end
        end
      end
      S_LATCH: begin
        if (phase == RST_END) begin
          latch_end = 1'b1;
          state_n   = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Phase restarts at each bit start and at the latch start; it keeps
  // counting across high->low so a bit always totals TBIT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if ((state_n != state) && ((state_n == S_HIGH) || (state_n == S_LATCH))) begin
      phase <= '0;
    end else if ((state == S_HIGH) || (state == S_LOW) || (state == S_LATCH)) begin
      phase <= phase + 1'b1;
    end else begin
      phase <= '0;
    end
  end

  // Shifter and bit index: load a fresh byte or advance to the next bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shifter <= '0;
      bit_idx <= '0;
    end else if (take_hold) begin
      shifter <= hold;
      bit_idx <= 3'd7;
    end else if (take_in) begin
      shifter <= in_data;
      bit_idx <= 3'd7;
    end else if (shift_en) begin
      shifter <= {shifter[6:0], 1'b0};
      bit_idx <= bit_idx - 3'd1;
    end
  end

  // Holding register: catches a byte while the shifter is still busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (frame_start || take_hold) begin
      hold_full <= 1'b0;
    end else if (hs && !take_in) begin
      hold      <= in_data;
      hold_full <= 1'b1;
    end
  end

  // Frame bookkeeping: length, accepted and sent byte counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bytecount_reg <= '0;
      accepted      <= '0;
      sent          <= '0;
    end else if (frame_start) begin
      bytecount_reg <= bytecount;
      accepted      <= '0;
      sent          <= '0;
    end else begin
      if (hs) begin
        accepted <= accepted + 16'd1;
      end
      if (byte_end) begin
        sent <= sent + 16'd1;
      end
    end
  end

  // Sticky underrun flag, cleared only by a new frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      underrun <= 1'b0;
    end else if (frame_start) begin
      underrun <= 1'b0;
    end else if (set_underrun) begin
      underrun <= 1'b1;
    end
  end

  // Registered line output tracks the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= 1'b0;
    end else begin
      dout <= (state_n == S_HIGH);
    end
  end

endmodule

// File: tb/tb_ws2812_tx.sv
// tb/tb_ws2812_tx.sv - directed self-checking bench for ws2812_tx
module tb_ws2812_tx;

  localparam int T0H  = 8;
  localparam int T1H  = 17;
  localparam int TBIT = 30;
  localparam int RC   = 1920;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bytecount = 16'd0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        dout;
  logic        busy;
  logic        done;
  logic        underrun;

  ws2812_tx #(
    .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .RESET_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bytecount(bytecount),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .dout(dout), .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int rises[$];
  int highs[$];
  int done_cnt = 0;
  int busy_cnt = 0;

  logic [7:0] src_q[$];
  int acc_cnt = 0;
  int hs_cyc  = -1;

  int start_cyc;
  int acc_base;
  int done_base;
  int busy_base;
  int dcyc;

  // Line monitor: rise times, high durations, done and busy counts.
  initial begin
    int rise_at;
    logic prev;
    rise_at = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (dout && !prev) begin
        rises.push_back(cyc);
        rise_at = cyc;
      end
      if (!dout && prev) highs.push_back(cyc - rise_at);
      prev = dout;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  // Byte source: presents the queue head, pops it after a handshake.
  initial begin
    logic hs_prev;
    hs_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (hs_prev && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        in_valid = 1'b1;
        in_data  = src_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'd0;
      end
      hs_prev = in_valid && in_ready && rst;
      if (hs_prev) begin
        acc_cnt++;
        hs_cyc = cyc;
      end
    end
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int bad_gaps(input int first, input int last);
    int bad;
    bad = 0;
    for (int i = first + 1; i <= last; i++)
      if (qat(rises, i) - qat(rises, i - 1) != TBIT) bad++;
    return bad;
  endfunction

  task automatic check_byte(input string tag, input int base, input logic [7:0] b);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_bit%0d", tag, i), qat(highs, base + i), b[7 - i] ? T1H : T0H);
  endtask

  task automatic clear_mon();
    rises.delete();
    highs.delete();
    acc_base  = acc_cnt;
    done_base = done_cnt;
    busy_base = busy_cnt;
  endtask

  task automatic do_start(input int bc);
    @(negedge clk);
    start     = 1'b1;
    bytecount = bc[15:0];
    start_cyc = cyc;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int when);
    int n;
    n = 0;
    when = -1;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      check({tag, "_done_timeout"}, 0, 1);
    end else begin
      when = cyc;
      check({tag, "_busy_at_done"}, busy, 1);
      @(negedge clk);
      check({tag, "_busy_after_done"}, busy, 0);
      check({tag, "_done_one_cycle"}, done, 0);
    end
  endtask

  task automatic wait_acc(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while ((acc_cnt - acc_base) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if ((acc_cnt - acc_base) < n) check({tag, "_acc_timeout"}, acc_cnt - acc_base, n);
  endtask

  task automatic wait_rises(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (rises.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (rises.size() < n) check({tag, "_rise_timeout"}, rises.size(), n);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_underrun", underrun, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0xA5
    clear_mon();
    src_q.push_back(8'hA5);
    do_start(1);
    check("t1_busy", busy, 1);
    wait_done("t1", 3000, dcyc);
    check("t1_nbits", highs.size(), 8);
    check_byte("t1", 0, 8'hA5);
    check("t1_gaps", bad_gaps(0, 7), 0);
    check("t1_first_rise", qat(rises, 0) - start_cyc, 2);
    check("t1_latch", dcyc - qat(rises, 7), TBIT - 1 + RC);
    check("t1_underrun", underrun, 0);
    check("t1_accepted", acc_cnt - acc_base, 1);
    check("t1_done_cnt", done_cnt - done_base, 1);

    // Back-to-back 0xFF,0x00,0x81 with an excess byte pending
    clear_mon();
    src_q.push_back(8'hFF);
    src_q.push_back(8'h00);
    src_q.push_back(8'h81);
    src_q.push_back(8'h55);
    do_start(3);
    wait_acc("t2", 3, 2000);
    repeat (5) @(negedge clk);
    check("t2_ready_low", in_ready, 0);
    check("t2_valid_high", in_valid, 1);
    wait_done("t2", 4000, dcyc);
    check("t2_nbits", highs.size(), 24);
    check_byte("t2_b0", 0, 8'hFF);
    check_byte("t2_b1", 8, 8'h00);
    check_byte("t2_b2", 16, 8'h81);
    check("t2_gaps", bad_gaps(0, 23), 0);
    check("t2_accepted", acc_cnt - acc_base, 3);
    check("t2_pending", src_q.size(), 1);
    check("t2_underrun", underrun, 0);
    src_q.delete();
    @(negedge clk);

    // Underrun: second byte withheld
    clear_mon();
    src_q.push_back(8'hC3);
    do_start(2);
    repeat (448) @(negedge clk);
    check("t3_underrun_set", underrun, 1);
    check("t3_stall_bits", rises.size(), 8);
    check("t3_stall_dout", dout, 0);
    check("t3_stall_busy", busy, 1);
    src_q.push_back(8'h5A);
    wait_acc("t3", 2, 100);
    wait_done("t3", 4000, dcyc);
    check("t3_nbits", highs.size(), 16);
    check_byte("t3_b0", 0, 8'hC3);
    check_byte("t3_b1", 8, 8'h5A);
    check("t3_resume", qat(rises, 8) - hs_cyc, 1);
    check("t3_gaps_b1", bad_gaps(8, 15), 0);
    check("t3_underrun_sticky", underrun, 1);

    // Zero-length frame; pending byte must not be taken
    clear_mon();
    src_q.push_back(8'h77);
    do_start(0);
    check("t4_underrun_clr", underrun, 0);
    check("t4_in_ready", in_ready, 0);
    wait_done("t4", 3000, dcyc);
    repeat (2) @(negedge clk);
    check("t4_done_at", dcyc - start_cyc, RC);
    check("t4_busy_cycles", busy_cnt - busy_base, RC);
    check("t4_no_pulse", rises.size(), 0);
    check("t4_accepted", acc_cnt - acc_base, 0);
    check("t4_done_cnt", done_cnt - done_base, 1);
    src_q.delete();
    @(negedge clk);

    // Second start mid-frame is ignored
    clear_mon();
    src_q.push_back(8'h3C);
    src_q.push_back(8'hE7);
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    src_q.push_back(8'h33);
    do_start(2);
    wait_rises("t5", 3, 500);
    start     = 1'b1;
    bytecount = 16'd5;
    @(negedge clk);
    start     = 1'b0;
    bytecount = 16'd0;
    wait_done("t5", 4000, dcyc);
    repeat (2) @(negedge clk);
    check("t5_nbits", highs.size(), 16);
    check_byte("t5_b0", 0, 8'h3C);
    check_byte("t5_b1", 8, 8'hE7);
    check("t5_gaps", bad_gaps(0, 15), 0);
    check("t5_accepted", acc_cnt - acc_base, 2);
    check("t5_done_cnt", done_cnt - done_base, 1);
    src_q.delete();
    @(negedge clk);

    // Asynchronous reset during a HIGH phase, then a fresh frame
    clear_mon();
    src_q.push_back(8'hFF);
    do_start(1);
    wait_rises("t6", 3, 500);
    #2;
    check("t6_pre_dout", dout, 1);
    rst = 1'b0;
    #1;
    check("t6_async_dout", dout, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    src_q.delete();
    @(negedge clk);
    clear_mon();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_idle_busy", busy, 0);
    src_q.push_back(8'h3C);
    do_start(1);
    wait_done("t6", 3000, dcyc);
    check("t6_nbits", highs.size(), 8);
    check_byte("t6_fresh", 0, 8'h3C);
    check("t6_first_rise", qat(rises, 0) - start_cyc, 2);
    check("t6_accepted", acc_cnt - acc_base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
